// File: rtl/rv_key_debouncer.sv
// rv_key_debouncer: synchronises and debounces an active-low key, with press/release strobes, sticky flag and press counter
module rv_key_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             key_raw_i,
  input  logic             clr_i,
  output logic             key_o,
  output logic             press_o,
  output logic             release_o,
  output logic             pressed_flag_o,
  output logic [CNT_W-1:0] press_cnt_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_key, r_press, r_release, r_flag;
  logic [CNT_W-1:0]       r_pcnt;
  logic                   w_sync, w_diff, w_term, w_press;
  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_diff  = w_sync != r_key;
  assign w_term  = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign w_press = w_term && !w_sync;
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_sync    <= '1;
      r_cnt     <= '0;
      r_key     <= 1'b1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_flag    <= 1'b0;
      r_pcnt    <= '0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], key_raw_i};
      // any agreement with the clean level restarts the full window
      r_cnt     <= (!w_diff || w_term) ? '0 : r_cnt + 1'b1;
      r_key     <= w_term ? w_sync : r_key;
      r_press   <= w_press;
      r_release <= w_term && w_sync;
      r_flag    <= w_press ? 1'b1 : (clr_i ? 1'b0 : r_flag);
      r_pcnt    <= w_press ? r_pcnt + 1'b1 : r_pcnt;
    end
  end
  assign key_o          = r_key;
  assign press_o        = r_press;
  assign release_o      = r_release;
  assign pressed_flag_o = r_flag;
  assign press_cnt_o    = r_pcnt;
endmodule

// File: tb/tb_rv_key_debouncer.sv
// tb_rv_key_debouncer: randomized and directed checks against a sample-window reference model
module tb_rv_key_debouncer;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 4;
  logic          clk_i = 1'b0, arstn_i = 1'b0, key_raw_i = 1'b1, clr_i = 1'b0;
  logic          key_o, press_o, release_o, pressed_flag_o;
  logic [CW-1:0] press_cnt_o;
  rv_key_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .key_raw_i(key_raw_i), .clr_i(clr_i),
    .key_o(key_o), .press_o(press_o), .release_o(release_o),
    .pressed_flag_o(pressed_flag_o), .press_cnt_o(press_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  int total = 0, bad = 0;
  string phase = "init";
  logic [SYNC+DEB-1:0] hist;
  logic m_key, m_press, m_rel, m_flag;
  int m_cnt;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s/%s got=%0h exp=%0h t=%0t", phase, tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    check("key", {31'd0, key_o}, {31'd0, m_key});
    check("press", {31'd0, press_o}, {31'd0, m_press});
    check("release", {31'd0, release_o}, {31'd0, m_rel});
    check("flag", {31'd0, pressed_flag_o}, {31'd0, m_flag});
    check("cnt", {28'd0, press_cnt_o}, m_cnt);
  endtask
  task automatic model_reset();
    hist = '1; m_key = 1'b1; m_press = 1'b0; m_rel = 1'b0; m_flag = 1'b0; m_cnt = 0;
  endtask
  // hist[k] is the raw value sampled k edges ago; the clean level flips once the
  // DEB most recent synchronised samples all disagree with it
  task automatic tick(input logic raw, input logic clr);
    logic flip;
    key_raw_i = raw; clr_i = clr;
    @(posedge clk_i);
    hist = {hist[SYNC+DEB-2:0], raw};
    flip = 1'b1;
    for (int k = SYNC; k < SYNC + DEB; k++) if (hist[k] == m_key) flip = 1'b0;
    m_press = flip && m_key;
    m_rel   = flip && !m_key;
    if (flip) m_key = !m_key;
    m_flag = m_press ? 1'b1 : (clr ? 1'b0 : m_flag);
    if (m_press) m_cnt = (m_cnt + 1) % (1 << CW);
    #1 check_all();
    @(negedge clk_i);
  endtask
  task automatic do_reset(input int cycles);
    @(negedge clk_i);
    arstn_i = 1'b0;
    #1 model_reset();
    check_all();
    repeat (cycles) @(negedge clk_i);
    check_all();
    arstn_i = 1'b1;
  endtask
  task automatic measure_latency(input string tag);
    int lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b0);
      if (press_o && lat == 0) lat = i;
    end
    check(tag, lat, 6);
  endtask
  initial begin
    phase = "reset";
    key_raw_i = 1'b0;
    do_reset(3);
    measure_latency("lat_rst");
    check("cnt_rst", {28'd0, press_cnt_o}, 1);
    phase = "clean";
    repeat (8) tick(1'b1, 1'b1);
    repeat (8) tick(1'b0, 1'b0);
    repeat (8) tick(1'b1, 1'b0);
    phase = "bounce";
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    repeat (6) tick(1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0);
    repeat (6) tick(1'b1, 1'b0);
    phase = "collide";
    repeat (8) tick(1'b0, 1'b1);
    check("flag_after_clr", {31'd0, pressed_flag_o}, 0);
    repeat (8) tick(1'b1, 1'b0);
    phase = "wrap";
    for (int p = 0; p < 16; p++) begin
      repeat (6) tick(1'b0, 1'b0);
      repeat (6) tick(1'b1, 1'b0);
    end
    phase = "midreset";
    repeat (3) tick(1'b0, 1'b0);
    arstn_i = 1'b0;
    #1 model_reset();
    check_all();
    #2 arstn_i = 1'b1;
    measure_latency("lat_mid");
    repeat (8) tick(1'b1, 1'b0);
    phase = "random";
    for (int s = 0; s < 300; s++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) tick(lvl, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 40) == 0) do_reset($urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_key_debouncer.md
Name: rv_key_debouncer

Overview:
Input-conditioning stage directly upstream of rv_key_device.
- Takes a raw, asynchronous, bouncing push-button line (active-low, as on board KEY pins).
- Synchronises it to the core clock and debounces it with a stability counter.
- Drives the clean level into the key device's key input.
- Also provides single-cycle press/release strobes, a sticky "pressed since last clear" flag and a wrapping press counter for diagnostics/LEDs.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flip-flops (legal range 2..4).
- DEBOUNCE_CYCLES, 500000, consecutive cycles the synchronised input must differ from the current clean level before the clean level flips (10 ms at 50 MHz; must be >= 2).
- CNT_W, 16, width of press_cnt_o.

Ports:
- clk_i, input, 1, core clock (CLOCK_50 domain).
- arstn_i, input, 1, asynchronous active-low reset.
- key_raw_i, input, 1, raw button line; 0 = pressed, 1 = released; asynchronous to clk_i.
- clr_i, input, 1, synchronous clear of pressed_flag_o.
- key_o, output, 1, debounced level, same polarity as key_raw_i; feeds rv_key_device key input.
- press_o, output, 1, one-cycle strobe on clean 1->0 transition.
- release_o, output, 1, one-cycle strobe on clean 0->1 transition.
- pressed_flag_o, output, 1, sticky flag, set by press, cleared by clr_i.
- press_cnt_o, output, CNT_W, number of debounced presses, modulo 2^CNT_W.

Behaviour:
- One clock. Reset is asynchronous, active-low on arstn_i. Every flop resets in the arstn_i branch; no synchronous reset.
- Reset values:
  - all synchroniser stages = 1; key_o = 1 (released);
  - press_o = 0, release_o = 0, pressed_flag_o = 0;
  - press_cnt_o = 0; stability counter = 0.
- Synchroniser: SYNC_STAGES-deep shift chain; sync = last stage. No logic between stages.
- Stability counter: width = clog2(DEBOUNCE_CYCLES).
  - sync == key_o: counter <= 0.
  - sync != key_o and counter != DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != key_o and counter == DEBOUNCE_CYCLES-1: key_o <= sync, counter <= 0.
  - Any return of sync to key_o before the terminal count clears the counter, so a bounce restarts the full window.
- Latency: let E0 be the first rising edge that samples the new key_raw_i value. key_o changes on edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1, provided the input stays stable throughout.
- Strobes:
  - press_o and release_o are registered, asserted high for exactly one cycle, on the same edge that key_o changes.
  - Never both high at once.
  - Low on every edge where key_o does not change.
- pressed_flag_o:
  - set on the edge press_o is asserted;
  - cleared on an edge with clr_i=1 and no press;
  - press and clr_i on the same edge: set wins (flag = 1).
- press_cnt_o: increments by 1 on the edge press_o is asserted; wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- Reset mid-operation: everything returns to reset values immediately; a button held through reset release produces a press after the full latency.
- Inputs are all synchronous except key_raw_i; clr_i is in the clk_i domain.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=4.
1. Reset: hold arstn_i=0 with key_raw_i=0 -> key_o=1, press_o=0, release_o=0, pressed_flag_o=0, press_cnt_o=0. Release reset with key_raw_i held 0 -> key_o falls on the 5th edge after the first sampling edge, press_o=1 for one cycle, press_cnt_o=1.
2. Clean press: key_raw_i 1->0, stable -> key_o=0 and press_o=1 on edge E0+5, press_cnt_o=1, pressed_flag_o=1. Clean release then gives release_o=1 on edge E0'+5.
3. Bounce rejection: key_raw_i low for 3 cycles, high for 1, low for 3, then high -> key_o stays 1, no strobes, press_cnt_o=0. A later stable low of >= 4 cycles -> exactly one press.
4. Flag/clear collision: clr_i=1 on the same edge as press_o -> pressed_flag_o=1. clr_i=1 on the following edge -> pressed_flag_o=0, press_cnt_o unchanged.
5. Counter wrap: 16 clean press/release pairs -> press_cnt_o goes 15 -> 0 on the 16th press, with press_o still pulsing.
6. Async reset mid-window: key_raw_i low, arstn_i pulsed low when counter=2 -> counter=0 and key_o=1 immediately. After release, a full 5-edge latency elapses before press_o.
